// File: rtl/seed_loader_if.sv
// Handshake bundle between the seed loader, the upstream LFSR and the downstream grid.
// The loader uses the slave modport; the LFSR/grid side uses master.
interface seed_loader_if;
    logic        start;
    logic [63:0] lfsr_seed;
    logic        shift_seed;
    logic [7:0]  row_data;
    logic [2:0]  row_idx;
    logic        row_valid;
    logic        row_ready;
    logic        busy;
    logic        done;
    logic        error;

    modport master (
        output start, lfsr_seed, row_ready,
        input  shift_seed, row_data, row_idx, row_valid, busy, done, error
    );

    modport slave (
        input  start, lfsr_seed, row_ready,
        output shift_seed, row_data, row_idx, row_valid, busy, done, error
    );
endinterface

// File: rtl/seed_loader.sv
// Warms up the upstream LFSR, captures a non-zero 64-bit seed and streams it out as
// eight 8-bit grid rows (MSB byte first) over a valid/ready handshake.
//   state   | meaning
//   IDLE    | waiting for start
//   ADVANCE | shift_seed high, warm-up down-counter running
//   CAPTURE | latch lfsr_seed; retry on zero, abort after MAX_RETRY zeros
//   SEND    | present rows 0..7, advance on row_ready
//   FINISH  | one-cycle done pulse, error qualifies it
module seed_loader #(
    parameter int WARMUP    = 4,
    parameter int MAX_RETRY = 3
) (
    input  logic         clk,
    input  logic         reset,
    seed_loader_if.slave bus
);
    typedef enum logic [2:0] {IDLE, ADVANCE, CAPTURE, SEND, FINISH} state_t;

    localparam logic [3:0] WARM_LOAD = 4'(WARMUP);
    localparam logic [2:0] RETRY_LIM = 3'(MAX_RETRY);

    state_t      state;
    logic [3:0]  warm_cnt;
    logic [2:0]  retry_cnt;
    logic [63:0] seed_reg;
    logic [2:0]  retry_next;
    logic [2:0]  idx_next;

    assign retry_next = retry_cnt + 3'd1;
    assign idx_next   = bus.row_idx + 3'd1;

    function automatic logic [7:0] pick_row(input logic [63:0] s, input logic [2:0] i);
        logic [63:0] sh;
        sh = s << {i, 3'b000};
        return sh[63:56];
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            warm_cnt       <= 4'd0;
            retry_cnt      <= 3'd0;
            seed_reg       <= 64'd0;
            bus.shift_seed <= 1'b0;
            bus.row_data   <= 8'd0;
            bus.row_idx    <= 3'd0;
            bus.row_valid  <= 1'b0;
            bus.busy       <= 1'b0;
            bus.done       <= 1'b0;
            bus.error      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state          <= ADVANCE;
                        warm_cnt       <= WARM_LOAD;
                        retry_cnt      <= 3'd0;
                        bus.shift_seed <= 1'b1;
                        bus.busy       <= 1'b1;
                        bus.error      <= 1'b0;
                    end
                end
                ADVANCE: begin
                    warm_cnt <= warm_cnt - 4'd1;
                    if (warm_cnt == 4'd1) begin
                        state          <= CAPTURE;
                        bus.shift_seed <= 1'b0;
                    end
                end
                CAPTURE: begin
                    seed_reg <= bus.lfsr_seed;
                    if (bus.lfsr_seed == 64'd0) begin
                        retry_cnt <= retry_next;
                        if (retry_next == RETRY_LIM) begin
                            state     <= FINISH;
                            bus.done  <= 1'b1;
                            bus.error <= 1'b1;
                        end else begin
                            state          <= ADVANCE;
                            warm_cnt       <= WARM_LOAD;
                            bus.shift_seed <= 1'b1;
                        end
                    end else begin
                        state         <= SEND;
                        bus.row_valid <= 1'b1;
                        bus.row_idx   <= 3'd0;
                        bus.row_data  <= bus.lfsr_seed[63:56];
                    end
                end
                SEND: begin
                    if (bus.row_ready) begin
                        // Last row holds its index so row_idx never shows 0 with valid high.
                        if (bus.row_idx == 3'd7) begin
                            state         <= FINISH;
                            bus.row_valid <= 1'b0;
                            bus.done      <= 1'b1;
                        end else begin
                            bus.row_idx  <= idx_next;
                            bus.row_data <= pick_row(seed_reg, idx_next);
                        end
                    end
                end
                FINISH: begin
                    state    <= IDLE;
                    bus.done <= 1'b0;
                    bus.busy <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_seed_loader.sv
// Directed and randomized checks of seed_loader against a schedule-level model of
// warm-up, capture/retry and row streaming, with an LFSR stand-in indexed by step count.
module tb_seed_loader;
    localparam int W  = 4;
    localparam int MR = 3;

    logic clk = 1'b0;
    logic reset;
    seed_loader_if bus();

    seed_loader #(.WARMUP(W), .MAX_RETRY(MR)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [63:0] caps [MR];
    int          ready_mode;
    int          reset_row;
    bit          spam;

    int          shift_cnt;
    int          done_cnt;
    int          first_rv;
    logic        err_at_done;
    bit          aborted;
    bit          finished;
    logic [10:0] xfers [$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_shift"}, bus.shift_seed, 0);
        check({tag, "_valid"}, bus.row_valid, 0);
        check({tag, "_data"},  bus.row_data, 0);
        check({tag, "_idx"},   bus.row_idx, 0);
        check({tag, "_busy"},  bus.busy, 0);
        check({tag, "_done"},  bus.done, 0);
        check({tag, "_error"}, bus.error, 0);
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    task automatic run_load();
        logic [63:0] lfsr_states [W*MR+1];
        int          steps;
        int          pat;
        bit          prev_sh, prev_rv, prev_rdy;
        logic [7:0]  prev_rd;
        logic [2:0]  prev_ri;

        foreach (lfsr_states[n]) lfsr_states[n] = rnd64();
        for (int k = 0; k < MR; k++) lfsr_states[W*(k+1)] = caps[k];
        steps = 0; pat = 0;
        prev_sh = 0; prev_rv = 0; prev_rdy = 0; prev_rd = 0; prev_ri = 0;
        shift_cnt = 0; done_cnt = 0; first_rv = -1; err_at_done = 1'bx;
        aborted = 0; finished = 0;
        xfers.delete();

        @(posedge clk); #1;
        bus.start     = 1'b1;
        bus.row_ready = 1'b0;
        bus.lfsr_seed = lfsr_states[0];

        for (int i = 1; i <= 300; i++) begin
            @(posedge clk); #1;
            bus.start = 1'b0;
            if (prev_sh) steps++;
            if (i == 1) check("error_cleared_on_start", bus.error, 0);
            check("busy", bus.busy, finished ? 64'd0 : 64'd1);
            if (bus.shift_seed) shift_cnt++;
            if (bus.row_valid && first_rv < 0) first_rv = i;
            if (prev_rv && prev_rdy) xfers.push_back({prev_ri, prev_rd});
            if (prev_rv && !prev_rdy) begin
                check("stall_valid", bus.row_valid, 1);
                check("stall_data", bus.row_data, prev_rd);
                check("stall_idx", bus.row_idx, prev_ri);
            end
            if (bus.done) begin
                done_cnt++;
                err_at_done = bus.error;
            end
            if (reset_row >= 0 && bus.row_valid && bus.row_idx == 3'(reset_row)) begin
                #2 reset = 1'b1;
                #1 check_all_zero("async_reset");
                aborted = 1;
                break;
            end
            if (finished) break;
            if (bus.done) finished = 1;

            prev_sh = bus.shift_seed;
            prev_rv = bus.row_valid;
            prev_rd = bus.row_data;
            prev_ri = bus.row_idx;

            case (ready_mode)
                0:       bus.row_ready = 1'b1;
                1:       bus.row_ready = (pat % 3 == 0);
                default: bus.row_ready = 1'($urandom_range(0, 1));
            endcase
            if (bus.row_valid) pat++;
            prev_rdy = bus.row_ready;
            // Random garbage while streaming: the captured seed must not follow it.
            if (bus.row_valid) bus.lfsr_seed = rnd64();
            else if (steps <= W*MR) bus.lfsr_seed = lfsr_states[steps];
            bus.start = spam && (bus.row_valid || bus.done);
        end
        check("load_terminated", finished || aborted, 1);
    endtask

    task automatic evaluate();
        int          k;
        int          exp_shifts;
        logic        exp_err;
        logic [63:0] s;
        k = -1;
        for (int j = 0; j < MR; j++) if (k < 0 && caps[j] != 64'd0) k = j;
        if (k < 0) begin
            exp_shifts = W * MR;
            exp_err    = 1'b1;
            check("no_rows", xfers.size(), 0);
            check("no_row_valid", first_rv < 0, 1);
        end else begin
            exp_shifts = W * (k + 1);
            exp_err    = 1'b0;
            s          = caps[k];
            check("latency", first_rv, (k + 1) * (W + 1) + 1);
            check("row_count", xfers.size(), 8);
            for (int r = 0; r < 8 && r < xfers.size(); r++)
                check($sformatf("row%0d", r), xfers[r], {3'(r), s[63-8*r -: 8]});
        end
        check("shift_cycles", shift_cnt, exp_shifts);
        check("done_count", done_cnt, 1);
        check("error_at_done", err_at_done, exp_err);
        check("error_held_idle", bus.error, exp_err);
        check("idle_after_done", bus.busy, 0);
    endtask

    task automatic setup(input logic [63:0] c0, input logic [63:0] c1, input logic [63:0] c2,
                         input int mode, input int rrow, input bit sp);
        caps[0] = c0; caps[1] = c1; caps[2] = c2;
        ready_mode = mode; reset_row = rrow; spam = sp;
    endtask

    initial begin
        logic [63:0] seed;
        logic [63:0] c [MR];
        int          zeros;

        bus.start = 1'b0; bus.row_ready = 1'b0; bus.lfsr_seed = 64'd0;
        reset = 1'b1;
        #2 check_all_zero("reset");
        repeat (2) @(posedge clk);
        @(negedge clk) reset = 1'b0;

        seed = 64'h0412_6424_0034_3C28;
        setup(seed, rnd64(), rnd64(), 0, -1, 0); run_load(); evaluate();
        setup(seed, rnd64(), rnd64(), 1, -1, 0); run_load(); evaluate();
        setup(64'd0, 64'hA5A5_0000_FFFF_0001, rnd64(), 0, -1, 0); run_load(); evaluate();
        setup(64'd0, 64'd0, 64'd0, 0, -1, 0); run_load(); evaluate();
        setup(seed, rnd64(), rnd64(), 2, -1, 0); run_load(); evaluate();

        setup(seed, rnd64(), rnd64(), 0, 3, 0); run_load();
        check("abort_flag", aborted, 1);
        check("abort_no_done", done_cnt, 0);
        bus.start = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk) reset = 1'b0;
        repeat (3) @(posedge clk);
        #1 check("idle_after_reset", bus.busy, 0);
        setup(seed, rnd64(), rnd64(), 0, -1, 0); run_load(); evaluate();

        setup(seed, rnd64(), rnd64(), 1, -1, 1); run_load(); evaluate();

        for (int t = 0; t < 12; t++) begin
            zeros = $urandom_range(0, MR);
            for (int j = 0; j < MR; j++) begin
                c[j] = rnd64();
                if (c[j] == 64'd0) c[j] = 64'd1;
                if (j < zeros) c[j] = 64'd0;
            end
            setup(c[0], c[1], c[2], $urandom_range(0, 2), -1, 1'($urandom_range(0, 1)));
            run_load();
            evaluate();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/seed_loader.md
SEED_LOADER -- requirements
Module: seed_loader

Interface
REQ-001 Parameter WARMUP, default 4: number of shift_seed pulses issued before each seed capture; legal range 1..15.
REQ-002 Parameter MAX_RETRY, default 3: number of all-zero captures tolerated before error; legal range 1..7.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high; clears all state immediately, independent of clk.
REQ-005 start  input  1  request to load a new grid; sampled only in IDLE.
REQ-006 lfsr_seed  input  64  current LFSR state from the upstream LFSR.
REQ-007 shift_seed  output  1  advance request to the upstream LFSR, one step per asserted cycle.
REQ-008 row_data  output  8  grid row payload.
REQ-009 row_idx  output  3  row number of row_data, 0..7.
REQ-010 row_valid  output  1  row_data/row_idx valid.
REQ-011 row_ready  input  1  downstream grid accepts the row.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 done  output  1  one-cycle pulse when a load completes or aborts.
REQ-014 error  output  1  qualifies done: 1 = aborted after MAX_RETRY zero seeds; held until next start.

Function
REQ-015 FSM states: IDLE, ADVANCE, CAPTURE, SEND, FINISH; one-hot or binary encoding is free.
REQ-016 IDLE: start=1 -> ADVANCE, warm-up counter loaded with WARMUP, retry counter cleared, error cleared; start=0 -> stay.
REQ-017 ADVANCE: shift_seed=1 every cycle; counter decrements; after exactly WARMUP cycles of shift_seed -> CAPTURE.
REQ-018 CAPTURE (one cycle, shift_seed=0): lfsr_seed latched into internal 64-bit seed register.
REQ-019 CAPTURE with lfsr_seed==0: retry counter increments; if new count < MAX_RETRY -> ADVANCE with counter reloaded; if equal -> FINISH with error=1, no rows sent.
REQ-020 CAPTURE with lfsr_seed!=0 -> SEND with row index 0.
REQ-021 SEND: row_valid=1; row_data = seed register bits [63-8*row_idx -: 8] (row 0 = bits 63:56, row 7 = bits 7:0).
REQ-022 Handshake: transfer occurs on a cycle with row_valid=1 and row_ready=1; row_idx increments by 1 on each transfer.
REQ-023 row_data and row_idx SHALL be stable while row_valid=1 and row_ready=0; row_valid never drops without a transfer.
REQ-024 Transfer of row 7 -> FINISH; row_idx does not wrap to 0 visibly while row_valid=1.
REQ-025 FINISH (one cycle): done=1 -> IDLE; a start asserted during FINISH is ignored.
REQ-026 start asserted while busy=1 is ignored with no effect on state or counters.
REQ-027 Latency: start in IDLE to first row_valid = WARMUP+2 cycles with non-zero seed and no retries.
REQ-028 Outputs shift_seed, row_valid, done, busy SHALL be registered or decoded from state only; no combinational path from row_ready or lfsr_seed to any output.
REQ-029 The seed register holds its value until the next CAPTURE; lfsr_seed changes during SEND have no effect on row_data.

Reset
REQ-030 On reset=1: state=IDLE, shift_seed=0, row_valid=0, row_data=0, row_idx=0, busy=0, done=0, error=0, seed register=0, all counters=0.
REQ-031 Reset asserted mid-ADVANCE or mid-SEND aborts immediately; no done pulse; after release the block waits in IDLE for start.

Verification
REQ-032 WARMUP=4, start pulse, lfsr_seed=64'h0412_6424_0034_3C28 at capture, row_ready=1 -> shift_seed high exactly 4 cycles; rows 0..7 = 04,12,64,24,00,34,3C,28 on consecutive cycles; done=1, error=0.
REQ-033 Same seed, row_ready toggled 1,0,0,1,... -> row_data/row_idx held during stalls; exactly 8 transfers; row order unchanged.
REQ-034 lfsr_seed=0 at first capture, non-zero at second -> retry count 1, total 8 shift_seed cycles, then normal 8-row send, error=0.
REQ-035 lfsr_seed held 0, MAX_RETRY=3 -> 3 captures, 12 shift_seed cycles, no row_valid, done=1 with error=1, back to IDLE.
REQ-036 reset asserted during SEND at row 3 -> all outputs 0 asynchronously, no done; subsequent start reloads from row 0.
REQ-037 start pulsed during SEND and during FINISH -> ignored; exactly one done per accepted start.
